// File: rtl/vectadd_pkg.sv
// Shared constants for the vector-add sequencing controller: state codes,
// register map, STATUS/CTRL field positions.
package vectadd_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOAD_A = 2'd1;
    localparam state_t ST_LOAD_B = 2'd2;
    localparam state_t ST_DRAIN  = 2'd3;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_DONE_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_ERR_BIT   = 3;
    localparam int unsigned STAT_STATE_LSB = 8;
    localparam int unsigned STAT_STATE_W   = 4;
    localparam int unsigned STAT_IDX_LSB   = 16;

    localparam int unsigned CTRL_CLEAR_BIT = 31;
    localparam int unsigned LEN_W          = 8;

endpackage

// File: rtl/vectadd_elem_buf.sv
// Element buffer: one write port that either stores or accumulates into the
// addressed word, plus one combinational read port. Storage is not reset.
module vectadd_elem_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              add_en_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              carry_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] wr_data_d;

    // carry_o is only meaningful on an accumulate write
    always_comb begin
        sum       = {1'b0, mem_q[waddr_i]} + {1'b0, wdata_i};
        carry_o   = add_en_i & sum[DATA_W];
        wr_data_d = add_en_i ? sum[DATA_W-1:0] : wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wr_data_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vectadd_seq_ctrl.sv
// Avalon-MM slave that frames one vector-add job: length, LEN A-words,
// LEN B-words (accumulated in place), then LEN result reads.
module vectadd_seq_ctrl
    import vectadd_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              busy,
    output logic              done
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   widx_q, widx_d;
    logic [IDX_W-1:0]   ridx_q, ridx_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic               wr, rd;
    logic [LEN_W-1:0]   wr_len;
    logic               len_ok;
    logic [LEN_W-1:0]   len_m1;
    logic               last_w, last_r;
    logic               buf_we, buf_add;
    logic [DATA_W-1:0]  buf_rdata;
    logic               buf_carry;
    logic [DATA_W-1:0]  status_word;

    assign wr     = chipselect & ~write_n;
    assign rd     = chipselect & ~read_n;
    assign wr_len = writedata[LEN_W-1:0];
    assign len_ok = (wr_len != '0) && (wr_len <= LEN_W'(MAX_LEN));
    assign len_m1 = len_q - LEN_W'(1);
    assign last_w = (LEN_W'(widx_q) == len_m1);
    assign last_r = (LEN_W'(ridx_q) == len_m1);

    assign busy = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign done = (state_q == ST_DRAIN);

    vectadd_elem_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_LEN),
        .IDX_W  (IDX_W)
    ) u_elem_buf (
        .clk_i    (clk),
        .we_i     (buf_we),
        .add_en_i (buf_add),
        .waddr_i  (widx_q),
        .wdata_i  (writedata),
        .raddr_i  (ridx_q),
        .rdata_o  (buf_rdata),
        .carry_o  (buf_carry)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        ridx_d  = ridx_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        buf_we  = 1'b0;
        buf_add = 1'b0;

        if (wr) begin
            case (address)
                ADDR_CTRL: begin
                    if (writedata[CTRL_CLEAR_BIT]) begin
                        state_d = ST_IDLE;
                        len_d   = '0;
                        widx_d  = '0;
                        ridx_d  = '0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b0;
                    end else if (state_q != ST_IDLE) begin
                        err_d = 1'b1;
                    end else if (len_ok) begin
                        len_d   = wr_len;
                        widx_d  = '0;
                        state_d = ST_LOAD_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ADDR_DATA: begin
                    case (state_q)
                        ST_LOAD_A: begin
                            buf_we = 1'b1;
                            if (last_w) begin
                                widx_d  = '0;
                                state_d = ST_LOAD_B;
                            end else begin
                                widx_d = widx_q + IDX_W'(1);
                            end
                        end
                        ST_LOAD_B: begin
                            buf_we  = 1'b1;
                            buf_add = 1'b1;
                            if (buf_carry) begin
                                ovf_d = 1'b1;
                            end
                            if (last_w) begin
                                widx_d  = '0;
                                ridx_d  = '0;
                                state_d = ST_DRAIN;
                            end else begin
                                widx_d = widx_q + IDX_W'(1);
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end else if (rd && (address == ADDR_DATA)) begin
            if (state_q == ST_DRAIN) begin
                if (last_r) begin
                    ridx_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    ridx_d = ridx_q + IDX_W'(1);
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // index field shows the write pointer while loading, else the read pointer
    always_comb begin
        status_word                                  = '0;
        status_word[STAT_BUSY_BIT]                   = busy;
        status_word[STAT_DONE_BIT]                   = done;
        status_word[STAT_OVF_BIT]                    = ovf_q;
        status_word[STAT_ERR_BIT]                    = err_q;
        status_word[STAT_STATE_LSB +: STAT_STATE_W]  = STAT_STATE_W'(state_q);
        status_word[STAT_IDX_LSB +: LEN_W]           = busy ? LEN_W'(widx_q) : LEN_W'(ridx_q);
    end

    always_comb begin
        readdata = '0;
        if (rd) begin
            case (address)
                ADDR_DATA:   readdata = (state_q == ST_DRAIN) ? buf_rdata : '0;
                ADDR_CTRL:   readdata = DATA_W'(len_q);
                ADDR_STATUS: readdata = status_word;
                default:     readdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            ridx_q  <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            ridx_q  <= ridx_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_vectadd_seq_ctrl.sv
// Scoreboard bench for vectadd_seq_ctrl: reads push expected responses from a
// job-level model; a negedge monitor pops and compares.
module tb_vectadd_seq_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busy;
    logic        done;

    vectadd_seq_ctrl #(
        .DATA_W  (32),
        .MAX_LEN (16),
        .IDX_W   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] rd;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Job-level model: phase 0 idle, 1 collecting A, 2 collecting B, 3 handing out sums
    int unsigned m_phase;
    int unsigned m_len;
    int unsigned m_cnt;
    logic [31:0] m_a[$];
    logic [31:0] m_res[$];
    bit          m_ovf;
    bit          m_err;

    function automatic void model_reset();
        m_phase = 0; m_len = 0; m_cnt = 0;
        m_a.delete(); m_res.delete();
        m_ovf = 0; m_err = 0;
    endfunction

    function automatic void model_write(input logic [1:0] a, input logic [31:0] d);
        logic [32:0] s;
        int unsigned l;
        l = int'(d[7:0]);
        if (a == 2'd1) begin
            if (d[31]) begin
                model_reset();
            end else if (m_phase != 0) begin
                m_err = 1;
            end else if (l >= 1 && l <= 16) begin
                m_len = l; m_cnt = 0; m_a.delete(); m_res.delete(); m_phase = 1;
            end else begin
                m_err = 1;
            end
        end else if (a == 2'd0) begin
            if (m_phase == 1) begin
                m_a.push_back(d);
                m_cnt++;
                if (m_cnt == m_len) begin m_phase = 2; m_cnt = 0; end
            end else if (m_phase == 2) begin
                s = {1'b0, m_a[m_cnt]} + {1'b0, d};
                if (s[32]) m_ovf = 1;
                m_res.push_back(s[31:0]);
                m_cnt++;
                if (m_cnt == m_len) begin m_phase = 3; m_cnt = 0; end
            end else begin
                m_err = 1;
            end
        end
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] st;
        int unsigned idx;
        if (m_phase == 1 || m_phase == 2) idx = m_cnt;
        else if (m_phase == 3) idx = m_len - m_res.size();
        else idx = 0;
        st = 32'h0;
        st[0] = (m_phase == 1 || m_phase == 2);
        st[1] = (m_phase == 3);
        st[2] = m_ovf;
        st[3] = m_err;
        st[11:8] = 4'(m_phase);
        st[23:16] = 8'(idx);
        return st;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = 32'h0;
        case (a)
            2'd0: begin
                if (m_phase == 3) begin
                    r = m_res.pop_front();
                    if (m_res.size() == 0) m_phase = 0;
                end else begin
                    m_err = 1;
                end
            end
            2'd1: r = 32'(m_len);
            2'd2: r = model_status();
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic bus_idle();
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        address = 2'd0; writedata = 32'h0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        model_write(a, d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic do_read(input logic [1:0] a, input string nm);
        exp_t e;
        e.nm   = nm;
        e.busy = (m_phase == 1 || m_phase == 2);
        e.done = (m_phase == 3);
        e.rd   = model_read(a);
        sb_q.push_back(e);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (chipselect && !read_n && !reset) begin
            if (sb_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_read: got readdata=%08h with nothing expected", readdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_checks++;
                if (readdata !== e.rd) begin
                    n_errors++;
                    $display("FAIL %s readdata: got %08h want %08h", e.nm, readdata, e.rd);
                end
                n_checks++;
                if (busy !== e.busy) begin
                    n_errors++;
                    $display("FAIL %s busy: got %b want %b", e.nm, busy, e.busy);
                end
                n_checks++;
                if (done !== e.done) begin
                    n_errors++;
                    $display("FAIL %s done: got %b want %b", e.nm, done, e.done);
                end
            end
        end
    end

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w = 32'hFFFF_FFF0 | (w & 32'hF);
        return w;
    endfunction

    task automatic maybe_peek();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k == 0) do_read(2'd2, "rnd_status");
        else if (k == 1) do_read(2'd1, "rnd_ctrl");
        else if (k == 2) do_read(2'd3, "rnd_rsvd");
        else if (k == 3) do_write(2'd3, $urandom);
    endtask

    initial begin
        logic [31:0] d;
        int unsigned len;
        int unsigned abort_at;
        bus_idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state, DATA read outside DRAIN
        do_read(2'd2, "reset_status");
        do_read(2'd0, "idle_data_read");
        do_read(2'd2, "status_err");

        // basic 3-element job
        do_write(2'd1, 32'h8000_0000);
        do_write(2'd1, 32'd3);
        do_read(2'd2, "load_a_status");
        do_write(2'd0, 32'd1); do_write(2'd0, 32'd2); do_write(2'd0, 32'd3);
        do_read(2'd2, "load_b_status");
        do_write(2'd0, 32'd10); do_write(2'd0, 32'd20); do_write(2'd0, 32'd30);
        do_read(2'd2, "done_after_last_b");
        do_read(2'd0, "sum0"); do_read(2'd0, "sum1"); do_read(2'd0, "sum2");
        do_read(2'd2, "status_after_drain");

        // carry sets sticky ovf
        do_write(2'd1, 32'd1);
        do_write(2'd0, 32'hFFFF_FFFF);
        do_write(2'd0, 32'd2);
        do_read(2'd0, "ovf_sum");
        do_read(2'd2, "ovf_sticky");
        do_write(2'd1, 32'h8000_0000);
        do_read(2'd2, "ovf_cleared");

        // length and state errors
        do_write(2'd1, 32'd0);
        do_read(2'd2, "len0_err");
        do_write(2'd1, 32'h8000_0000);
        do_write(2'd1, 32'd17);
        do_read(2'd2, "len17_err");
        do_write(2'd1, 32'h8000_0000);
        do_write(2'd0, 32'd5);
        do_read(2'd2, "idle_write_err");
        do_write(2'd1, 32'h8000_0000);
        do_write(2'd1, 32'd3);
        do_write(2'd1, 32'd5);
        do_read(2'd1, "len_kept");
        do_read(2'd2, "ctrl_in_load_err");

        // abort mid-load, then a fresh job
        do_write(2'd1, 32'h8000_0000);
        do_write(2'd1, 32'd4);
        do_write(2'd0, 32'd9); do_write(2'd0, 32'd9);
        do_write(2'd1, 32'h8000_0000);
        do_read(2'd2, "abort_status");
        do_write(2'd1, 32'd1);
        do_write(2'd0, 32'd7); do_write(2'd0, 32'd8);
        do_read(2'd0, "after_abort_sum");

        // reset mid-drain
        do_write(2'd1, 32'd3);
        for (int i = 0; i < 6; i++) do_write(2'd0, 32'(i * 5 + 1));
        do_read(2'd0, "pre_reset_sum");
        do_reset();
        do_read(2'd2, "post_reset_status");
        do_read(2'd0, "post_reset_data");

        // randomized jobs with interleaved peeks and faults
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 3) == 0) do_write(2'd1, 32'h8000_0000 | $urandom);
            len = $urandom_range(1, 16);
            if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
            d = $urandom;
            d[31] = 1'b0;
            d[7:0] = 8'(len);
            do_write(2'd1, d);
            abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2 * len) : 1000;
            for (int i = 0; i < 2 * int'(len) && i < 32; i++) begin
                if (i == int'(abort_at)) do_write(2'd1, 32'h8000_0000);
                do_write(2'd0, rand_word());
                maybe_peek();
            end
            for (int i = 0; i < int'(len) && i < 16; i++) begin
                do_read(2'd0, "rnd_sum");
                maybe_peek();
            end
            do_read(2'd2, "rnd_job_end");
        end

        repeat (2) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
